// File: rtl/pc_fetch_unit.sv
// Fetch front end: owns the PC, issues one imem read at a time, delivers {pc, pc+4, instr} to IF/ID.
// Latency: ack at edge N -> if_valid after edge N; backpressure: id_stall parks one word in a skid, then drops imem_req.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] pc_next;
  logic [31:0] redirect_tgt;
  logic        slot_free;

  assign pc_next      = fetch_pc + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign slot_free    = !if_valid || !id_stall;

  // imem_addr is its own register so it can keep presenting the abandoned
  // request address in DRAIN while fetch_pc already points at the target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      skid_pc     <= 32'h0;
      skid_instr  <= NOP_INSTR;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_instr    <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      fetch_pc <= redirect_tgt;
      imem_req <= 1'b1;
      if (imem_req && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state     <= FETCH;
        imem_addr <= redirect_tgt;
      end
    end else begin
      case (state)
        IDLE: begin
          state     <= FETCH;
          imem_req  <= 1'b1;
          imem_addr <= fetch_pc;
        end
        FETCH: begin
          if (imem_ack) begin
            fetch_pc  <= pc_next;
            imem_addr <= pc_next;
            if (slot_free) begin
              if_valid    <= 1'b1;
              if_pc       <= fetch_pc;
              if_pc_plus4 <= pc_next;
              if_instr    <= imem_rdata;
            end else begin
              skid_pc    <= fetch_pc;
              skid_instr <= imem_rdata;
              state      <= FULL;
              imem_req   <= 1'b0;
            end
          end else if (slot_free) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
          end
        end
        FULL: begin
          if (!id_stall) begin
            if_valid    <= 1'b1;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + 32'd4;
            if_instr    <= skid_instr;
            state       <= FETCH;
            imem_req    <= 1'b1;
            imem_addr   <= fetch_pc;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state     <= FETCH;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  a_req_stable: assert property (@(posedge clk)
    (rst_n && imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  a_plus4: assert property (@(posedge clk)
    if_valid |-> (if_pc_plus4 == if_pc + 32'd4));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, all checked
// against a queue-based behavioural model of the fetch front end.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;

  pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a pending-request flag, a waiting-word queue and the output slot.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  bit          m_started;
  bit          m_draining;
  logic [31:0] m_fetch_pc;
  logic [31:0] m_drain_addr;
  ent_t        m_skid[$];
  bit          m_ov;
  logic [31:0] m_opc;
  logic [31:0] m_op4;
  logic [31:0] m_oi;

  function automatic bit m_req();
    return m_started && (m_draining || m_skid.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_draining ? m_drain_addr : m_fetch_pc;
  endfunction

  task automatic model_reset();
    m_started  = 0;
    m_draining = 0;
    m_fetch_pc = RST_PC;
    m_drain_addr = RST_PC;
    m_skid.delete();
    m_ov  = 0;
    m_opc = 32'h0;
    m_op4 = 32'h0;
    m_oi  = NOP;
  endtask

  task automatic step();
    bit          r;
    bit          free;
    logic [31:0] a;
    ent_t        e;
    r = m_req();
    a = m_addr();
    imem_rdata = a ^ KEY;
    check_eq("imem_req", imem_req, r);
    if (r) check_eq("imem_addr", imem_addr, a);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (redirect_valid) begin
        if (r && !imem_ack) begin
          m_drain_addr = a;
          m_draining   = 1;
        end else begin
          m_draining = 0;
        end
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
        m_skid.delete();
        m_ov = 0;
        m_oi = NOP;
      end else if (m_draining) begin
        if (imem_ack) m_draining = 0;
      end else begin
        free = !m_ov || !id_stall;
        if (m_skid.size() > 0) begin
          if (!id_stall) begin
            e     = m_skid.pop_front();
            m_ov  = 1;
            m_opc = e.pc;
            m_op4 = e.pc + 32'd4;
            m_oi  = e.instr;
          end
        end else if (r) begin
          if (imem_ack) begin
            if (free) begin
              m_ov  = 1;
              m_opc = m_fetch_pc;
              m_op4 = m_fetch_pc + 32'd4;
              m_oi  = m_fetch_pc ^ KEY;
            end else begin
              e.pc    = m_fetch_pc;
              e.instr = m_fetch_pc ^ KEY;
              m_skid.push_back(e);
            end
            m_fetch_pc = m_fetch_pc + 32'd4;
          end else if (free) begin
            m_ov = 0;
            m_oi = NOP;
          end
        end
      end
      m_started = 1;
    end
    check_eq("if_valid", if_valid, m_ov);
    check_eq("if_pc", if_pc, m_opc);
    check_eq("if_pc_plus4", if_pc_plus4, m_op4);
    check_eq("if_instr", if_instr, m_oi);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, if_valid, 1'b0);
    check_eq({tag, "_pc"}, if_pc, 32'h0);
    check_eq({tag, "_pc4"}, if_pc_plus4, 32'h0);
    check_eq({tag, "_instr"}, if_instr, NOP);
    check_eq({tag, "_req"}, imem_req, 1'b0);
  endtask

  initial begin
    logic [31:0] held;
    int          wcnt;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset_vals("reset");

    // Zero-wait memory: one instruction per cycle from the second cycle.
    rst_n = 1'b1;
    imem_ack = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("t1_pc", if_pc, 32'(k * 4));
      check_eq("t1_valid", if_valid, 1'b1);
    end

    // Stall: one word parks, requests stop, release continues without gap.
    held = if_pc;
    id_stall = 1'b1;
    step();
    step();
    check_eq("t3_req_off", imem_req, 1'b0);
    repeat (3) step();
    id_stall = 1'b0;
    step();
    check_eq("t3_pc_a", if_pc, held + 32'd4);
    step();
    check_eq("t3_pc_b", if_pc, held + 32'd8);

    // Ack arriving three cycles after each request.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (m_req()) begin
        imem_ack = (wcnt == 3);
        wcnt = (wcnt == 3) ? 0 : wcnt + 1;
      end else begin
        imem_ack = 1'b0;
      end
      step();
    end

    // Redirect while the request to 0x10 is outstanding.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 20 && m_addr() != 32'h10; i++) step();
    check_eq("t4_addr_pre", imem_addr, 32'h10);
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check_eq("t4_drain_addr", imem_addr, 32'h10);
    step();
    imem_ack = 1'b1;
    step();
    check_eq("t4_new_addr", imem_addr, 32'h100);
    step();
    check_eq("t4_if_pc", if_pc, 32'h100);
    check_eq("t4_if_valid", if_valid, 1'b1);

    // Redirect coinciding with a stall and a full skid.
    id_stall = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    id_stall = 1'b0;
    check_eq("t5_valid", if_valid, 1'b0);
    check_eq("t5_req", imem_req, 1'b1);
    check_eq("t5_addr", imem_addr, 32'h200);
    step();
    step();

    // Address wrap, then reset in the middle of a drain.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("t6_pc0", if_pc, 32'hFFFF_FFF8);
    step();
    check_eq("t6_pc1", if_pc, 32'hFFFF_FFFC);
    check_eq("t6_pc1_p4", if_pc_plus4, 32'h0);
    step();
    check_eq("t6_pc2", if_pc, 32'h0);
    imem_ack = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    step();
    check_reset_vals("t6_rst");
    rst_n = 1'b1;
    imem_ack = 1'b1;
    step();
    step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom();
      id_stall       = ($urandom_range(0, 2) == 0);
      imem_ack       = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
